// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and strobe sequencer sharing the CalcuTEC register file
// between the execution unit (requester 0) and the keypad/display unit (requester 1).
module regfile_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [1:0]      wr,
  input  logic [2*AW-1:0] addr_a,
  input  logic [2*AW-1:0] addr_b,
  input  logic [2*AW-1:0] addr_w,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata_a,
  output logic [DW-1:0]   rdata_b,
  output logic            reg_read,
  output logic            reg_write,
  output logic [AW-1:0]   dirA,
  output logic [AW-1:0]   dirB,
  output logic [AW-1:0]   dir_WR,
  output logic [DW-1:0]   data_in,
  input  logic [DW-1:0]   datA,
  input  logic [DW-1:0]   datB
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   rr;
  logic   winner;
  logic   op_wr;
  logic   pick;

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // A lone requester always wins; rr only breaks ties.
  always_comb begin
    pick = rr;
    if (req == 2'b01)      pick = 1'b0;
    else if (req == 2'b10) pick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      winner    <= 1'b0;
      op_wr     <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      dirA      <= '0;
      dirB      <= '0;
      dir_WR    <= '0;
      data_in   <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner    <= pick;
            op_wr     <= wr[pick];
            dirA      <= pick ? addr_a[2*AW-1:AW] : addr_a[AW-1:0];
            dirB      <= pick ? addr_b[2*AW-1:AW] : addr_b[AW-1:0];
            dir_WR    <= pick ? addr_w[2*AW-1:AW] : addr_w[AW-1:0];
            data_in   <= pick ? wdata[2*DW-1:DW]  : wdata[DW-1:0];
            gnt       <= onehot(pick);
            reg_read  <= ~wr[pick];
            reg_write <= wr[pick];
            state     <= ISSUE;
          end
        end
        // Strobe cycle: writes complete next, reads wait one cycle for datA/datB.
        ISSUE: begin
          if (op_wr) begin
            done  <= onehot(winner);
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rdata_a <= datA;
          rdata_b <= datB;
          done    <= onehot(winner);
          state   <= DONE;
        end
        DONE: begin
          rr    <= ~winner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized scoreboard bench for regfile_arbiter with a transaction-level
// reference model and a behavioural register-file stub.
module tb_regfile_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      wr = '0;
  logic [2*AW-1:0] addr_a = '0;
  logic [2*AW-1:0] addr_b = '0;
  logic [2*AW-1:0] addr_w = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata_a;
  logic [DW-1:0]   rdata_b;
  logic            reg_read;
  logic            reg_write;
  logic [AW-1:0]   dirA;
  logic [AW-1:0]   dirB;
  logic [AW-1:0]   dir_WR;
  logic [DW-1:0]   data_in;
  logic [DW-1:0]   datA = '0;
  logic [DW-1:0]   datB = '0;

  regfile_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr),
    .addr_a(addr_a), .addr_b(addr_b), .addr_w(addr_w), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .reg_read(reg_read), .reg_write(reg_write),
    .dirA(dirA), .dirB(dirB), .dir_WR(dir_WR), .data_in(data_in),
    .datA(datA), .datB(datB)
  );

  always #5 clk = ~clk;

  // Register file stub: commits on the falling edge of the write cycle,
  // presents read data in the cycle after the read strobe.
  logic [DW-1:0] rf_mem [16];
  always @(negedge clk) if (reg_write) rf_mem[dir_WR] = data_in;
  always @(posedge clk) if (reg_read) begin
    datA <= rf_mem[dirA];
    datB <= rf_mem[dirB];
  end

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] aa, ab, aw;
    logic [DW-1:0] wd, ra, rb;
    int            cyc;
  } txn_t;

  txn_t gq[$];
  txn_t dq[$];
  int   gnt_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ntx = 0;
  int free_at = 0;
  int m_rr = 0;
  int mode = 0;
  logic [DW-1:0] m_mem [16];

  logic [1:0]    pend = '0;
  logic          c_wr [2];
  logic [AW-1:0] c_aa [2];
  logic [AW-1:0] c_ab [2];
  logic [AW-1:0] c_aw [2];
  logic [DW-1:0] c_wd [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    free_at = 0;
    gq.delete();
    dq.delete();
  endtask

  // Transaction-level model: serialized ops, round-robin on ties, fixed latencies.
  task automatic model_sample();
    txn_t r;
    txn_t d;
    int   w;
    if (rst_n && cyc >= free_at && req != 2'b00) begin
      if (req == 2'b11)      w = m_rr;
      else if (req == 2'b10) w = 1;
      else                   w = 0;
      r.id = w; r.wr = c_wr[w]; r.aa = c_aa[w]; r.ab = c_ab[w];
      r.aw = c_aw[w]; r.wd = c_wd[w]; r.ra = '0; r.rb = '0; r.cyc = cyc;
      if (r.wr) begin
        m_mem[r.aw] = r.wd;
        free_at = cyc + 3;
      end else begin
        r.ra = m_mem[r.aa];
        r.rb = m_mem[r.ab];
        free_at = cyc + 4;
      end
      gq.push_back(r);
      d = r;
      d.cyc = cyc + (r.wr ? 1 : 2);
      dq.push_back(d);
      m_rr = 1 - w;
      pend[w] = 1'b0;
      ntx++;
    end
  endtask

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] aw, input logic [DW-1:0] d);
    pend[i] = 1'b1; c_wr[i] = w; c_aa[i] = a; c_ab[i] = b; c_aw[i] = aw; c_wd[i] = d;
  endtask

  task automatic gen();
    for (int i = 0; i < 2; i++)
      if (!pend[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 3) != 0)))
        set_cmd(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic drive();
    req    = pend;
    wr     = {c_wr[1], c_wr[0]};
    addr_a = {c_aa[1], c_aa[0]};
    addr_b = {c_ab[1], c_ab[0]};
    addr_w = {c_aw[1], c_aw[0]};
    wdata  = {c_wd[1], c_wd[0]};
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_sample();
    #1;
    gen();
    drive();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((pend != 2'b00 || gq.size() != 0 || dq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check({"drain_", nm}, 64'(n < 200), 64'(1));
    step();
  endtask

  // Monitor: every cycle compares DUT outputs with what the scoreboard says is due.
  logic [AW-1:0] mon_da = '0, mon_db = '0, mon_dw = '0;
  logic [DW-1:0] mon_wd = '0, mon_ra = '0, mon_rb = '0;

  always @(negedge clk) begin : mon
    txn_t r;
    logic [1:0] exp_gnt, exp_done;
    logic exp_rd, exp_wr;
    if (!rst_n) begin
      mon_da = '0; mon_db = '0; mon_dw = '0; mon_wd = '0; mon_ra = '0; mon_rb = '0;
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_strobes", 64'({reg_read, reg_write}), 64'(0));
      check("rst_dirs", 64'({dirA, dirB, dir_WR}), 64'(0));
      check("rst_data_in", 64'(data_in), 64'(0));
      check("rst_rdata", {rdata_a, rdata_b}, 64'(0));
    end else begin
      exp_gnt = '0; exp_done = '0; exp_rd = 1'b0; exp_wr = 1'b0;
      if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        r = gq.pop_front();
        exp_gnt = (r.id == 1) ? 2'b10 : 2'b01;
        exp_rd = ~r.wr; exp_wr = r.wr;
        mon_da = r.aa; mon_db = r.ab; mon_dw = r.aw; mon_wd = r.wd;
      end
      if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        r = dq.pop_front();
        exp_done = (r.id == 1) ? 2'b10 : 2'b01;
        if (!r.wr) begin mon_ra = r.ra; mon_rb = r.rb; end
      end
      if (gnt == 2'b01) gnt_log.push_back(0);
      if (gnt == 2'b10) gnt_log.push_back(1);
      check("gnt", 64'(gnt), 64'(exp_gnt));
      check("done", 64'(done), 64'(exp_done));
      check("reg_read", 64'(reg_read), 64'(exp_rd));
      check("reg_write", 64'(reg_write), 64'(exp_wr));
      check("dirA", 64'(dirA), 64'(mon_da));
      check("dirB", 64'(dirB), 64'(mon_db));
      check("dir_WR", 64'(dir_WR), 64'(mon_dw));
      check("data_in", 64'(data_in), 64'(mon_wd));
      check("rdata_a", 64'(rdata_a), 64'(mon_ra));
      check("rdata_b", 64'(rdata_b), 64'(mon_rb));
    end
  end

  initial begin
    int base;
    int g;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = $urandom;
      rf_mem[i] = m_mem[i];
    end
    m_mem[0] = 32'hA5A5A5A5;
    rf_mem[0] = 32'hA5A5A5A5;
    for (int i = 0; i < 2; i++) begin
      c_wr[i] = 1'b0; c_aa[i] = '0; c_ab[i] = '0; c_aw[i] = '0; c_wd[i] = '0;
    end

    // Reset with both requesters already asserting, then contention.
    set_cmd(0, 1'b0, 4'd1, 4'd2, 4'd7, 32'h0);
    set_cmd(1, 1'b0, 4'd4, 4'd5, 4'd8, 32'h0);
    drive();
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    mode = 1;
    g = 0;
    while (ntx < 4 && g < 100) begin step(); g++; end
    mode = 0;
    drain("contention");
    check("grant_count", 64'(gnt_log.size() >= 4), 64'(1));
    if (gnt_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("grant_order", 64'(gnt_log[i]), 64'(i % 2));

    // Single write then read-after-write from the other requester.
    set_cmd(0, 1'b1, 4'd0, 4'd0, 4'd3, 32'h12345678);
    drive();
    drain("write");
    set_cmd(1, 1'b0, 4'd3, 4'd0, 4'd9, 32'hDEADBEEF);
    drive();
    drain("raw");
    check("raw_rdata_a", 64'(rdata_a), 64'(32'h12345678));
    check("raw_rdata_b", 64'(rdata_b), 64'(32'hA5A5A5A5));

    // Abort a read during WAIT.
    set_cmd(1, 1'b0, 4'd3, 4'd0, 4'd2, 32'h0);
    drive();
    base = ntx;
    g = 0;
    while (ntx == base && g < 50) begin step(); g++; end
    step();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    check("abort_rdata_a", 64'(rdata_a), 64'(0));
    rst_n = 1'b1;
    set_cmd(0, 1'b0, 4'd3, 4'd6, 4'd1, 32'h0);
    drive();
    drain("post_abort");

    // rr now favours requester 1; a lone requester 0 must still win at once.
    set_cmd(0, 1'b1, 4'd0, 4'd0, 4'd5, 32'hCAFEF00D);
    drive();
    drain("lone");
    base = gnt_log.size();
    set_cmd(0, 1'b0, 4'd5, 4'd3, 4'd0, 32'h0);
    set_cmd(1, 1'b0, 4'd3, 4'd5, 4'd0, 32'h0);
    drive();
    drain("tie_after_lone");
    check("tie_count", 64'(gnt_log.size() - base), 64'(2));
    if (gnt_log.size() >= base + 2) begin
      check("tie_first", 64'(gnt_log[base]), 64'(1));
      check("tie_second", 64'(gnt_log[base + 1]), 64'(0));
    end

    // Random traffic.
    mode = 2;
    repeat (600) step();
    mode = 0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
